// File: rtl/cpx_mult_sched_pkg.sv
// cpx_mult_sched_pkg: shared types, default widths and helpers for the complex-multiplier scheduler
// Contents: state_e (FLUSH, RUN, DRAIN, IDLE), default parameter values, clog2 (never below 1).
package cpx_mult_sched_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int X_BITS_DEF = 12;
  localparam int Y_BITS_DEF = 12;
  localparam int OUT_BITS_DEF = 24;
  localparam int MULT_LAT_DEF = 5;
  typedef enum logic [1:0] {FLUSH, RUN, DRAIN, IDLE} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/cpx_mult_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over N requesters starting at a pointer
// Ports: req (request vector), ptr (highest-priority index), gnt (one-hot or zero),
//        idx (granted index, 0 when none), any (at least one request present).
module rr_arbiter
  import cpx_mult_sched_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |req;
    // Walk offsets from farthest to nearest so the nearest request to ptr wins.
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/cpx_mult_sched.sv
// cpx_mult_sched: round-robin scheduler sharing one fixed-latency complex multiplier among N_REQ requesters
// Ports: clk, rst_n (sync, active-low), enable; per-requester req_valid/req_ready and packed
//        operands req_xi/xq/yi/yq; multiplier side mult_tready, mult_x/y_tvalid, mult_xi/xq/yi/yq,
//        mult_i/mult_q; tagged result stream res_valid/res_tag/res_i/res_q; busy.
// Option: define CPX_MULT_SCHED_STATS_EN to add 32-bit stat_grants and stat_idle counters.
module cpx_mult_sched
  import cpx_mult_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int X_BITS   = X_BITS_DEF,
  parameter int Y_BITS   = Y_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int TAG_W    = clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*X_BITS-1:0]    req_xi,
  input  logic [N_REQ*X_BITS-1:0]    req_xq,
  input  logic [N_REQ*Y_BITS-1:0]    req_yi,
  input  logic [N_REQ*Y_BITS-1:0]    req_yq,
  output logic                       mult_tready,
  output logic                       mult_x_tvalid,
  output logic                       mult_y_tvalid,
  output logic signed [X_BITS-1:0]   mult_xi,
  output logic signed [X_BITS-1:0]   mult_xq,
  output logic signed [Y_BITS-1:0]   mult_yi,
  output logic signed [Y_BITS-1:0]   mult_yq,
  input  logic signed [OUT_BITS-1:0] mult_i,
  input  logic signed [OUT_BITS-1:0] mult_q,
  output logic                       res_valid,
  output logic [TAG_W-1:0]           res_tag,
  output logic signed [OUT_BITS-1:0] res_i,
  output logic signed [OUT_BITS-1:0] res_q,
  output logic                       busy
`ifdef CPX_MULT_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_grants,
  output logic [31:0]                stat_idle
`endif
);
  state_e state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic [MULT_LAT-1:0] tv_q, tv_d;
  logic [MULT_LAT-1:0][TAG_W-1:0] tt_q, tt_d;
  logic [N_REQ-1:0] arb_gnt;
  logic [TAG_W-1:0] arb_idx;
  logic arb_any, act, grant;
  rr_arbiter #(.N(N_REQ), .W(TAG_W)) u_arb (
    .req(req_valid),
    .ptr(rr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  always_comb begin
    // The multiplier only advances on valid&tready, so holding it still during reset and IDLE
    // keeps its pipeline aligned with the tag line.
    act = rst_n && state_q != IDLE;
    grant = state_q == RUN && enable && arb_any;
    req_ready = grant ? arb_gnt : '0;
    mult_tready = act;
    mult_x_tvalid = act;
    mult_y_tvalid = act;
    mult_xi = grant ? req_xi[arb_idx*X_BITS +: X_BITS] : '0;
    mult_xq = grant ? req_xq[arb_idx*X_BITS +: X_BITS] : '0;
    mult_yi = grant ? req_yi[arb_idx*Y_BITS +: Y_BITS] : '0;
    mult_yq = grant ? req_yq[arb_idx*Y_BITS +: Y_BITS] : '0;
    res_valid = tv_q[MULT_LAT-1];
    res_tag = res_valid ? tt_q[MULT_LAT-1] : '0;
    res_i = mult_i;
    res_q = mult_q;
    busy = state_q != IDLE || |tv_q;
    rr_d = grant ? (arb_idx == TAG_W'(N_REQ - 1) ? '0 : arb_idx + TAG_W'(1)) : rr_q;
    tv_d = act ? {tv_q[MULT_LAT-2:0], grant} : tv_q;
    tt_d = act ? {tt_q[MULT_LAT-2:0], arb_idx} : tt_q;
    fcnt_d = (state_q == FLUSH && fcnt_q != 8'(MULT_LAT - 1)) ? fcnt_q + 8'd1 : '0;
    state_d = state_q;
    case (state_q)
      FLUSH: if (fcnt_q == 8'(MULT_LAT - 1)) state_d = enable ? RUN : IDLE;
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: if (!(|tv_q)) state_d = IDLE;
      IDLE:  if (enable) state_d = RUN;
      default: state_d = FLUSH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      fcnt_q <= '0;
      rr_q <= '0;
      tv_q <= '0;
      tt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      rr_q <= rr_d;
      tv_q <= tv_d;
      tt_q <= tt_d;
    end
  end
`ifdef CPX_MULT_SCHED_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d, stat_idle_q, stat_idle_d;
  always_comb begin
    stat_grants_d = stat_grants_q + 32'(grant);
    stat_idle_d = stat_idle_q + 32'(state_q == RUN && !grant);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants_q <= '0;
      stat_idle_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_idle_q <= stat_idle_d;
    end
  end
  assign stat_grants = stat_grants_q;
  assign stat_idle = stat_idle_q;
`endif
endmodule
